// File: rtl/pixel_priority_readout_pkg.sv
// ---------------------------------------------------------------------------
// pixel_readout_pkg
// Shared constants, FSM state type and helpers for the column-end pixel
// readout. Imported by the bus interface, the per-half readout engine and
// the top level.
//   NPIX / HALF_PIX : total pixels / pixels handled by one half
//   TIME_W / IDX_W  : time stamp width / in-half index width
//   ADDR_W          : output word width, {idx, time}
//   CLR_TIMEOUT     : SETTLE cycles allowed for a pixel to drop its hit flag
// ---------------------------------------------------------------------------
package pixel_readout_pkg;

  localparam int NPIX        = 180;
  localparam int HALF_PIX    = 90;
  localparam int TIME_W      = 8;
  localparam int IDX_W       = 7;
  localparam int ADDR_W      = IDX_W + TIME_W;
  localparam int CLR_TIMEOUT = 8;
  localparam int CNT_W       = $clog2(CLR_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    OUT,
    CLR,
    SETTLE
  } rd_state_t;

  // Output word layout: pixel index in the upper bits, time stamp below.
  function automatic logic [ADDR_W-1:0] pack_addr(input logic [IDX_W-1:0]  idx,
                                                  input logic [TIME_W-1:0] tstamp);
    return {idx, tstamp};
  endfunction

  // In-half pixel that sits k positions after 'base', wrapping 89 -> 0.
  // base + 1 + k never exceeds 2*HALF_PIX - 1, so one subtraction suffices.
  function automatic int wrap_idx(input int base, input int k);
    int j;
    j = base + 1 + k;
    return (j >= HALF_PIX) ? j - HALF_PIX : j;
  endfunction

endpackage

// File: rtl/pixel_priority_readout_if.sv
// ---------------------------------------------------------------------------
// pixel_readout_if
// Valid/ready word bus carrying one readout word from a half to its consumer.
//   valid : word present (producer)
//   addr  : {idx[6:0], time[7:0]} (producer)
//   ready : consumer accepts (consumer)
// ---------------------------------------------------------------------------
interface pixel_readout_if import pixel_readout_pkg::*; ();

  logic              valid;
  logic [ADDR_W-1:0] addr;
  logic              ready;

  modport master (output valid, output addr, input  ready);
  modport slave  (input  valid, input  addr, output ready);

endinterface

// File: rtl/pixel_priority_readout_half.sv
// ---------------------------------------------------------------------------
// pixel_half_readout
// Readout engine for one 90-pixel half: priority encoder, IDLE/ADDR/OUT/
// CLR/SETTLE FSM and clear-timeout counter.
//   clk, rst_n  : clock, asynchronous active-low reset
//   state_i     : per-pixel hit flags of this half
//   time_i      : per-pixel time stamps, pixel k at [k*8 +: 8]
//   addren_o    : one-hot address enable of the pixel being read
//   sync_o      : one-cycle clear pulse to the pixel just read
//   clr_err_o   : sticky flag, pixel did not clear within CLR_TIMEOUT cycles
//   rd_bus      : word output (master side of the valid/ready bus)
// Build option: READOUT_RR_EN selects round-robin priority (search starts
// after the previously selected pixel); otherwise lowest index wins.
// ---------------------------------------------------------------------------
module pixel_half_readout
  import pixel_readout_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [HALF_PIX-1:0]        state_i,
  input  logic [HALF_PIX*TIME_W-1:0] time_i,
  output logic [HALF_PIX-1:0]        addren_o,
  output logic [HALF_PIX-1:0]        sync_o,
  output logic                       clr_err_o,
  pixel_readout_if.master            rd_bus
);

  rd_state_t            state_q;
  logic [IDX_W-1:0]     idx_q;
  logic [TIME_W-1:0]    time_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [HALF_PIX-1:0]  addren_q;
  logic [HALF_PIX-1:0]  sync_q;
  logic                 valid_q;
  logic                 err_q;
`ifdef READOUT_RR_EN
  logic [IDX_W-1:0]     last_q;
`endif

  logic                 sel_hit_d;
  logic [IDX_W-1:0]     sel_idx_d;

  // Priority encoder. Scanning from the lowest priority up to the highest
  // lets the last match found be the winner.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // condition, otherwise the unassigned paths infer latches.
    sel_hit_d = 1'b0;
    sel_idx_d = '0;
    for (int k = HALF_PIX - 1; k >= 0; k--) begin
`ifdef READOUT_RR_EN
      if (state_i[wrap_idx(int'(last_q), k)]) begin
        sel_hit_d = 1'b1;
        sel_idx_d = IDX_W'(wrap_idx(int'(last_q), k));
      end
`else
      if (state_i[k]) begin
        sel_hit_d = 1'b1;
        sel_idx_d = IDX_W'(k);
      end
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      time_q   <= '0;
      cnt_q    <= '0;
      addren_q <= '0;
      sync_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
`ifdef READOUT_RR_EN
      last_q   <= IDX_W'(HALF_PIX - 1);  // first search starts at pixel 0
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (sel_hit_d) begin
            idx_q    <= sel_idx_d;
            addren_q <= HALF_PIX'(1) << sel_idx_d;
`ifdef READOUT_RR_EN
            last_q   <= sel_idx_d;
`endif
            state_q  <= ADDR;
          end
        end
        ADDR: begin
          // ADDREN has been high all of this cycle; the pixel's time stamp
          // is valid at its end.
          time_q  <= time_i[int'(idx_q) * TIME_W +: TIME_W];
          valid_q <= 1'b1;
          state_q <= OUT;
        end
        OUT: begin
          if (rd_bus.ready) begin
            valid_q        <= 1'b0;
            addren_q       <= '0;
            sync_q[idx_q]  <= 1'b1;
            state_q        <= CLR;
          end
        end
        CLR: begin
          sync_q  <= '0;
          state_q <= SETTLE;
        end
        SETTLE: begin
          if (!state_i[idx_q]) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else if (cnt_q == CNT_W'(CLR_TIMEOUT - 1)) begin
            // Pixel ignored the clear; flag it and allow it to be re-read.
            err_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign addren_o     = addren_q;
  assign sync_o       = sync_q;
  assign clr_err_o    = err_q;
  assign rd_bus.valid = valid_q;
  assign rd_bus.addr  = pack_addr(idx_q, time_q);

endmodule

// File: rtl/pixel_priority_readout.sv
// ---------------------------------------------------------------------------
// pixel_priority_readout
// Column-end readout for the 180-pixel array, split into two independent
// halves (down = pixels 0..89, up = pixels 90..179).
//   sys_clock, sys_resetn : clock, asynchronous active-low reset
//   STATE, timeCnt        : per-pixel hit flag and 8-bit time stamp
//   ADDREN, SYNC          : per-pixel address enable / clear pulse
//   down_*, up_*          : per-half valid/ready word outputs
//   clr_err_o             : sticky clear-timeout flags {up, down}
// Build option: READOUT_RR_EN (round-robin priority inside each half).
// ---------------------------------------------------------------------------
module pixel_priority_readout
  import pixel_readout_pkg::*;
(
  input  logic                   sys_clock,
  input  logic                   sys_resetn,
  input  logic [NPIX-1:0]        STATE,
  input  logic [NPIX*TIME_W-1:0] timeCnt,
  output logic [NPIX-1:0]        ADDREN,
  output logic [NPIX-1:0]        SYNC,
  output logic                   down_valid_o,
  output logic [ADDR_W-1:0]      down_addr_o,
  input  logic                   down_ready_i,
  output logic                   up_valid_o,
  output logic [ADDR_W-1:0]      up_addr_o,
  input  logic                   up_ready_i,
  output logic [1:0]             clr_err_o
);

  localparam int HALF_T = HALF_PIX * TIME_W;

  pixel_readout_if dn_bus ();
  pixel_readout_if up_bus ();

  logic [HALF_PIX-1:0] dn_addren, up_addren, dn_sync, up_sync;
  logic                dn_err, up_err;

  pixel_half_readout u_down (
    .clk       (sys_clock),
    .rst_n     (sys_resetn),
    .state_i   (STATE[HALF_PIX-1:0]),
    .time_i    (timeCnt[HALF_T-1:0]),
    .addren_o  (dn_addren),
    .sync_o    (dn_sync),
    .clr_err_o (dn_err),
    .rd_bus    (dn_bus.master)
  );

  pixel_half_readout u_up (
    .clk       (sys_clock),
    .rst_n     (sys_resetn),
    .state_i   (STATE[NPIX-1:HALF_PIX]),
    .time_i    (timeCnt[NPIX*TIME_W-1:HALF_T]),
    .addren_o  (up_addren),
    .sync_o    (up_sync),
    .clr_err_o (up_err),
    .rd_bus    (up_bus.master)
  );

  assign ADDREN       = {up_addren, dn_addren};
  assign SYNC         = {up_sync, dn_sync};
  assign clr_err_o    = {up_err, dn_err};

  assign down_valid_o = dn_bus.valid;
  assign down_addr_o  = dn_bus.addr;
  assign dn_bus.ready = down_ready_i;
  assign up_valid_o   = up_bus.valid;
  assign up_addr_o    = up_bus.addr;
  assign up_bus.ready = up_ready_i;

endmodule

// File: tb/tb_pixel_priority_readout.sv
// ---------------------------------------------------------------------------
// tb_pixel_priority_readout
// Bench for pixel_priority_readout. A small pixel model clears a hit one
// edge after its SYNC pulse (unless marked stuck); expected words are queued
// per half from the readout rules and compared as words are accepted.
// ---------------------------------------------------------------------------
module tb_pixel_priority_readout;
  import pixel_readout_pkg::*;

  logic                   clk        = 1'b0;
  logic                   sys_resetn = 1'b1;
  logic [NPIX-1:0]        state_r    = '0;
  logic [NPIX-1:0]        stuck      = '0;
  logic [NPIX-1:0]        sync_s     = '0;
  logic [NPIX*TIME_W-1:0] time_r     = '0;
  logic [NPIX-1:0]        addren;
  logic [NPIX-1:0]        sync;
  logic [1:0]             clr_err;

  pixel_readout_if dn_bus ();
  pixel_readout_if up_bus ();

  int checks = 0;
  int errors = 0;

  logic [ADDR_W-1:0] exp_dn[$];
  logic [ADDR_W-1:0] exp_up[$];
  logic              dn_hold, up_hold;
  logic [ADDR_W-1:0] dn_held, up_held;

  always #5 clk = ~clk;

  pixel_priority_readout dut (
    .sys_clock    (clk),
    .sys_resetn   (sys_resetn),
    .STATE        (state_r),
    .timeCnt      (time_r),
    .ADDREN       (addren),
    .SYNC         (sync),
    .down_valid_o (dn_bus.valid),
    .down_addr_o  (dn_bus.addr),
    .down_ready_i (dn_bus.ready),
    .up_valid_o   (up_bus.valid),
    .up_addr_o    (up_bus.addr),
    .up_ready_i   (up_bus.ready),
    .clr_err_o    (clr_err)
  );

  task automatic check(input string tag, input logic [NPIX-1:0] obs,
                       input logic [NPIX-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ADDR_W-1:0] exp_word(input int pix, input int t);
    int idx;
    idx = (pix >= HALF_PIX) ? pix - HALF_PIX : pix;
    return {IDX_W'(idx), TIME_W'(t)};
  endfunction

  function automatic logic [NPIX-1:0] bit_at(input int pix);
    logic [NPIX-1:0] v;
    v = '0;
    v[pix] = 1'b1;
    return v;
  endfunction

  task automatic set_pix(input int pix, input int t);
    state_r[pix] = 1'b1;
    time_r[pix*TIME_W +: TIME_W] = TIME_W'(t);
  endtask

  // One clock: score the handshake about to happen, advance the pixel model
  // just after the edge, then observe outputs on the falling edge.
  task automatic cycle();
    if (dn_bus.valid && dn_bus.ready) begin
      check("dn_word_expected", exp_dn.size() != 0, 1);
      if (exp_dn.size() != 0) check("dn_word", dn_bus.addr, exp_dn.pop_front());
    end
    if (up_bus.valid && up_bus.ready) begin
      check("up_word_expected", exp_up.size() != 0, 1);
      if (exp_up.size() != 0) check("up_word", up_bus.addr, exp_up.pop_front());
    end
    dn_hold = dn_bus.valid && !dn_bus.ready;
    up_hold = up_bus.valid && !up_bus.ready;
    dn_held = dn_bus.addr;
    up_held = up_bus.addr;
    sync_s  = sync;
    @(posedge clk);
    #1;
    state_r = state_r & ~(sync_s & ~stuck);
    @(negedge clk);
    if (dn_hold) begin
      check("dn_hold_valid", dn_bus.valid, 1);
      check("dn_hold_addr", dn_bus.addr, dn_held);
    end
    if (up_hold) begin
      check("up_hold_valid", up_bus.valid, 1);
      check("up_hold_addr", up_bus.addr, up_held);
    end
    check("sync_addren_overlap", sync & addren, '0);
    check("dn_addren_onehot", $countones(addren[HALF_PIX-1:0]) <= 1, 1);
    check("up_addren_onehot", $countones(addren[NPIX-1:HALF_PIX]) <= 1, 1);
  endtask

  task automatic drain(input string tag, input int budget, input bit rnd_ready);
    int n;
    n = 0;
    while ((exp_dn.size() != 0 || exp_up.size() != 0) && n < budget) begin
      if (rnd_ready) begin
        dn_bus.ready = 1'($urandom_range(0, 1));
        up_bus.ready = 1'($urandom_range(0, 1));
      end
      cycle();
      n++;
    end
    check({tag, "_timeout"}, n < budget, 1);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    sys_resetn   = 1'b0;
    state_r      = '0;
    stuck        = '0;
    sync_s       = '0;
    dn_bus.ready = 1'b0;
    up_bus.ready = 1'b0;
    exp_dn.delete();
    exp_up.delete();
    repeat (2) @(negedge clk);
    sys_resetn = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addren"}, addren, '0);
    check({tag, "_sync"}, sync, '0);
    check({tag, "_dn_valid"}, dn_bus.valid, 0);
    check({tag, "_dn_addr"}, dn_bus.addr, 0);
    check({tag, "_up_valid"}, up_bus.valid, 0);
    check({tag, "_up_addr"}, up_bus.addr, 0);
    check({tag, "_err"}, clr_err, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    dn_bus.ready = 1'b0;
    up_bus.ready = 1'b0;

    // Reset state.
    apply_reset();
    check_all_zero("reset");
    cycle();
    check_all_zero("idle_no_hit");

    // Single hit on pixel 95 (up index 5), consumer always ready.
    set_pix(95, 8'h63);
    up_bus.ready = 1'b1;
    exp_up.push_back(exp_word(95, 8'h63));
    cycle();
    check("single_addren", addren, bit_at(95));
    check("single_up_valid_n1", up_bus.valid, 0);
    cycle();
    check("single_up_valid", up_bus.valid, 1);
    check("single_up_addr", up_bus.addr, {7'd5, 8'h63});
    check("single_addren_out", addren, bit_at(95));
    cycle();
    check("single_sync", sync, bit_at(95));
    check("single_up_valid_clr", up_bus.valid, 0);
    check("single_addren_clr", addren, '0);
    cycle();
    check("single_sync_pulse", sync, '0);
    repeat (3) begin
      cycle();
      check("single_dn_quiet", dn_bus.valid, 0);
    end
    check("single_queue", exp_up.size(), 0);

    // All pixels hit, time = i + 4, both consumers always ready.
    apply_reset();
    dn_bus.ready = 1'b1;
    up_bus.ready = 1'b1;
    for (int i = 0; i < NPIX; i++) begin
      set_pix(i, i + 4);
      if (i < HALF_PIX) exp_dn.push_back(exp_word(i, i + 4));
      else              exp_up.push_back(exp_word(i, i + 4));
    end
    drain("all_hit", 1000, 1'b0);
    repeat (4) cycle();
    check("all_hit_cleared", state_r, '0);
    check("all_hit_err", clr_err, 0);

    // Backpressure on pixel 3.
    apply_reset();
    set_pix(3, 8'h5A);
    exp_dn.push_back(exp_word(3, 8'h5A));
    cycle();
    cycle();
    check("bp_valid", dn_bus.valid, 1);
    check("bp_addr", dn_bus.addr, {7'd3, 8'h5A});
    repeat (9) begin
      cycle();
      check("bp_no_sync", sync, '0);
      check("bp_addren", addren, bit_at(3));
    end
    dn_bus.ready = 1'b1;
    cycle();
    check("bp_sync", sync, bit_at(3));
    check("bp_queue", exp_dn.size(), 0);

    // Stuck pixel 10: timeout after 8 SETTLE cycles, then re-read.
    apply_reset();
    dn_bus.ready = 1'b1;
    stuck[10] = 1'b1;
    set_pix(10, 8'h11);
    exp_dn.push_back(exp_word(10, 8'h11));
    exp_dn.push_back(exp_word(10, 8'h11));
    repeat (3) cycle();
    check("stuck_sync", sync, bit_at(10));
    n = 0;
    while (clr_err[0] !== 1'b1 && n < 20) begin
      cycle();
      n++;
    end
    check("stuck_err_latency", n, 9);
    stuck[10] = 1'b0;
    drain("stuck_reread", 50, 1'b0);
    repeat (4) cycle();
    check("stuck_err_sticky", clr_err, 2'b01);
    check("stuck_cleared", state_r[10], 0);

    // Reset during OUT on pixel 100 (up index 10).
    apply_reset();
    set_pix(100, 8'hC7);
    exp_up.push_back(exp_word(100, 8'hC7));
    cycle();
    cycle();
    check("rst_out_valid", up_bus.valid, 1);
    sys_resetn = 1'b0;
    #1;
    check_all_zero("rst_mid");
    exp_up.delete();
    sync_s = '0;
    @(negedge clk);
    check("rst_hold_sync", sync, '0);
    sys_resetn   = 1'b1;
    up_bus.ready = 1'b1;
    exp_up.push_back(exp_word(100, 8'hC7));
    drain("rst_reread", 20, 1'b0);

    // Priority order: pixels 2 and 5, pixel 2 re-hit right after its clear.
    apply_reset();
    dn_bus.ready = 1'b1;
    set_pix(2, 8'h22);
    set_pix(5, 8'h55);
    exp_dn.push_back(exp_word(2, 8'h22));
`ifdef READOUT_RR_EN
    exp_dn.push_back(exp_word(5, 8'h55));
    exp_dn.push_back(exp_word(2, 8'h2B));
`else
    exp_dn.push_back(exp_word(2, 8'h2B));
    exp_dn.push_back(exp_word(5, 8'h55));
`endif
    repeat (3) cycle();
    check("order_sync2", sync, bit_at(2));
    cycle();
    cycle();
    set_pix(2, 8'h2B);
    drain("order", 40, 1'b0);

    // Randomized hit sets and random backpressure; static hits come out in
    // ascending in-half order under either priority scheme after reset.
    for (int r = 0; r < 4; r++) begin
      apply_reset();
      for (int i = 0; i < NPIX; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          int t;
          t = int'($urandom_range(0, 255));
          set_pix(i, t);
          if (i < HALF_PIX) exp_dn.push_back(exp_word(i, t));
          else              exp_up.push_back(exp_word(i, t));
        end
      end
      drain("random", 2000, 1'b1);
      repeat (4) cycle();
      check("random_cleared", state_r, '0);
      check("random_err", clr_err, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
